div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
Shares one iterative unsigned divider (go/busy interface, 2W/W -> W quotient, W remainder, overflow flag) among NREQ requesters. Round-robin grant, operand muxing and go sequencing. Captures results and returns them to the granted requester with a one-cycle ack pulse. Sits between CPU/coprocessor ports and the single divider instance in the math unit.

Parameters:
WIDTH, 32, divisor/quotient/remainder width; dividend is 2*WIDTH.
NREQ, 4, number of requesters (2..8).
IDXW, 2, grant index width, equals clog2(NREQ).

Ports:
clk  in  1  clock, all logic on rising edge.
rstn  in  1  reset, synchronous, active-low.
req  in  NREQ  per-requester request level; held high with operands stable until ack.
dividend  in  NREQ*2*WIDTH  packed operands, requester i at bits [i*2*WIDTH +: 2*WIDTH].
divisor  in  NREQ*WIDTH  packed operands, requester i at bits [i*WIDTH +: WIDTH].
ack  out  NREQ  one-hot, one-cycle pulse: result for that requester is valid.
quot  out  WIDTH  registered quotient, valid while ack is high.
rem  out  WIDTH  registered remainder, valid while ack is high.
overflow  out  1  registered overflow, valid while ack is high.
grant_idx  out  IDXW  index of the current or last granted requester.
active  out  1  high from grant until the DONE cycle, inclusive.
div_go  out  1  one-cycle start strobe to the divider.
div_dividend  out  2*WIDTH  registered operand to the divider.
div_divisor  out  WIDTH  registered operand to the divider.
div_busy  in  1  divider busy.
div_quot  in  WIDTH  divider result.
div_rem  in  WIDTH  divider result.
div_overflow  in  1  divider result.

Behaviour:
- Reset (rstn low at clk edge) gives: state IDLE, ack=0, div_go=0, active=0, quot=rem=0, overflow=0, grant_idx=NREQ-1 (so requester 0 wins first), div_dividend=div_divisor=0, cancel flag=0.
- Reset mid-operation aborts the transaction. No ack is issued. The divider is not reset by this block, so after reset IDLE waits for div_busy=0 before it issues a new go.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - Grant requires |req and div_busy=0.
  - Pick the first requester with req high, searching from grant_idx+1 modulo NREQ upward.
  - Latch grant_idx and that requester's operands into div_dividend/div_divisor. Set active. Go to START.
- START: div_go=1 for exactly one cycle. Go to WAIT.
- WAIT:
  - While div_busy=1, stay in WAIT.
  - When div_busy=0, register div_quot/div_rem/div_overflow into quot/rem/overflow, then go to DONE.
  - The overflow path (high half >= divisor, including divisor=0) returns busy=0 in the first WAIT cycle.
- DONE:
  - ack[grant_idx]=1 unless the cancel flag is set. Clear active and the cancel flag. Go to IDLE.
  - A requester holding req after its ack is re-arbitrated normally; it is lowest priority next round.
- Latency from req sampled in IDLE to ack: WIDTH+3 cycles for a normal divide, 3 cycles for overflow. Back-to-back throughput: one result per WIDTH+4 cycles.
- Cancel: if req[grant_idx] drops during START or WAIT, set the cancel flag.
  - The FSM still waits out the divider.
  - quot/rem/overflow are still updated, but no ack is pulsed.
- Simultaneous requests: only the round-robin pointer decides; there are no fixed priorities. Requests arriving during a transaction wait; none are dropped.
- Arithmetic is done entirely in the divider; this block only muxes and registers.

Decomposition:
- Shared package div_pkg: FSM state encoding (IDLE=0, START=1, WAIT=2, DONE=3) and the default WIDTH/NREQ constants.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are req and the last index; outputs are a valid flag and the next index. It is reused by other shared-resource arbiters.

Test Plan:
- Single request: req[0]=1, dividend=100, divisor=7 -> ack[0] at WIDTH+3 cycles, quot=14, rem=2, overflow=0, exactly one div_go pulse.
- Overflow: req[2]=1, dividend={32'd5, 32'd0}, divisor=3 -> ack[2] 3 cycles after the req is sampled, quot=rem=32'hFFFFFFFF, overflow=1. Repeat with divisor=0 -> same response.
- Round-robin: all four req held high from reset -> acks in order 0,1,2,3,0, spaced WIDTH+4 cycles apart, each with its own correct quotient and remainder.
- Cancel: req[1] dropped 5 cycles into WAIT -> no ack[1], the FSM returns to IDLE only after div_busy falls, then pending req[3] is granted next.
- Reset mid-WAIT with the divider still busy: rstn low for 1 cycle -> all outputs return to reset values; the next div_go is not issued until div_busy=0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: state encoding and default sizes shared by the divider arbiter
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_NREQ = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searches upward from the slot after i_last
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic            o_valid,
    output logic [IDXW-1:0] o_idx
);
    assign o_valid = |i_req;
    // scanned farthest-first so the nearest requester after i_last overwrites the rest
    always_comb begin
        o_idx = i_last;
        for (int i = NREQ; i >= 1; i--)
            if (i_req[IDXW'((int'(i_last) + i) % NREQ)]) o_idx = IDXW'((int'(i_last) + i) % NREQ);
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among NREQ requesters
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int NREQ = DIV_NREQ,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*2*WIDTH-1:0] dividend,
    input  logic [NREQ*WIDTH-1:0]   divisor,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        quot,
    output logic [WIDTH-1:0]        rem,
    output logic                    overflow,
    output logic [IDXW-1:0]         grant_idx,
    output logic                    active,
    output logic                    div_go,
    output logic [2*WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    input  logic                    div_busy,
    input  logic [WIDTH-1:0]        div_quot,
    input  logic [WIDTH-1:0]        div_rem,
    input  logic                    div_overflow
);
    logic [1:0]         r_state;
    logic               r_cancel;
    logic               w_valid;
    logic [IDXW-1:0]    w_next;
    logic [2*WIDTH-1:0] w_dd;
    logic [WIDTH-1:0]   w_dv;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .i_req(req),
        .i_last(grant_idx),
        .o_valid(w_valid),
        .o_idx(w_next)
    );

    always_comb begin
        w_dd = '0;
        w_dv = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_next == IDXW'(i)) begin
                w_dd = dividend[i*2*WIDTH +: 2*WIDTH];
                w_dv = divisor[i*WIDTH +: WIDTH];
            end
    end

    assign div_go = r_state == S_START;
    assign active = r_state != S_IDLE;
    assign ack = (r_state == S_DONE && !r_cancel) ? (NREQ'(1) << grant_idx) : '0;

    // the divider survives our reset, so IDLE must also see it idle before a new go
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cancel <= 1'b0;
            grant_idx <= IDXW'(NREQ - 1);
            quot <= '0;
            rem <= '0;
            overflow <= 1'b0;
            div_dividend <= '0;
            div_divisor <= '0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (w_valid && !div_busy) begin
                        grant_idx <= w_next;
                        div_dividend <= w_dd;
                        div_divisor <= w_dv;
                        r_state <= S_START;
                    end
                S_START: begin
                    if (!req[grant_idx]) r_cancel <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!req[grant_idx]) r_cancel <= 1'b1;
                    if (!div_busy) begin
                        quot <= div_quot;
                        rem <= div_rem;
                        overflow <= div_overflow;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_cancel <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed vectors and corner sequences against a behavioural divider
module tb_div_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*2*W-1:0] dividend = '0;
    logic [N*W-1:0] divisor = '0;
    logic [N-1:0] ack;
    logic [W-1:0] quot, rem;
    logic overflow, active, div_go;
    logic [1:0] grant_idx;
    logic [2*W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic div_busy = 1'b0;
    logic [W-1:0] div_quot = '0;
    logic [W-1:0] div_rem = '0;
    logic div_overflow = 1'b0;

    int m_cnt = 0;
    logic [2*W-1:0] m_q = '0;
    logic [2*W-1:0] m_r = '0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int go_cnt = 0;

    div_arbiter dut (
        .clk(clk), .rstn(rstn), .req(req), .dividend(dividend), .divisor(divisor),
        .ack(ack), .quot(quot), .rem(rem), .overflow(overflow), .grant_idx(grant_idx),
        .active(active), .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_quot(div_quot), .div_rem(div_rem), .div_overflow(div_overflow)
    );

    always #5 clk = ~clk;

    // divider: overflow answers at once, otherwise busy for W cycles; not reset by rstn
    always @(posedge clk) begin
        if (div_go) begin
            if (div_dividend[2*W-1:W] >= div_divisor) begin
                div_quot <= '1;
                div_rem <= '1;
                div_overflow <= 1'b1;
            end else begin
                div_busy <= 1'b1;
                m_cnt <= W;
                m_q <= div_dividend / {{W{1'b0}}, div_divisor};
                m_r <= div_dividend % {{W{1'b0}}, div_divisor};
            end
        end else if (div_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_busy <= 1'b0;
                div_quot <= m_q[W-1:0];
                div_rem <= m_r[W-1:0];
                div_overflow <= 1'b0;
            end
        end
    end

    typedef struct {
        int id;
        logic [63:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic ov;
        int lat;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (div_go) go_cnt++;
    endtask

    task automatic set_op(input int i, input logic [63:0] dd, input logic [31:0] dv);
        dividend[i*64 +: 64] = dd;
        divisor[i*32 +: 32] = dv;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_go"}, 64'(div_go), 64'd0);
        chk({tag, "_active"}, 64'(active), 64'd0);
        chk({tag, "_quot"}, 64'(quot), 64'd0);
        chk({tag, "_rem"}, 64'(rem), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_gidx"}, 64'(grant_idx), 64'd3);
        chk({tag, "_dd"}, div_dividend, 64'd0);
        chk({tag, "_dv"}, 64'(div_divisor), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] eq[4];
        logic [31:0] er[4];
        int ord[5];
        int found, last, ack1_cnt, ack3_at, go_at;
        logic seen;
        eq = '{32'd14, 32'd22, 32'd27, 32'd30};
        er = '{32'd2, 32'd2, 32'd3, 32'd10};
        ord = '{0, 1, 2, 3, 0};
        vt[0] = '{0, 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35};
        vt[1] = '{2, {32'd5, 32'd0}, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3};
        vt[2] = '{2, {32'd5, 32'd0}, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3};
        vt[3] = '{1, 64'd1000000, 32'd33, 32'd30303, 32'd1, 1'b0, 35};
        vt[4] = '{3, {32'd2, 32'd0}, 32'd5, 32'd1717986918, 32'd2, 1'b0, 35};
        vt[5] = '{1, {32'd7, 32'd9}, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3};
        vt[6] = '{0, 64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 35};

        repeat (2) step();
        chk_reset("rst");
        rstn = 1'b1;
        step();

        for (int k = 0; k < 7; k++) begin
            set_op(vt[k].id, vt[k].dd, vt[k].dv);
            req[vt[k].id] = 1'b1;
            cyc = 0;
            go_cnt = 0;
            seen = 1'b0;
            while (cyc < 100 && !seen) begin
                step();
                if (cyc == 1) chk($sformatf("v%0d_active", k), 64'(active), 64'd1);
                if (ack != 0) seen = 1'b1;
            end
            chk($sformatf("v%0d_ack", k), 64'(ack), 64'(4'b1 << vt[k].id));
            chk($sformatf("v%0d_lat", k), 64'(cyc), 64'(vt[k].lat));
            chk($sformatf("v%0d_quot", k), 64'(quot), 64'(vt[k].q));
            chk($sformatf("v%0d_rem", k), 64'(rem), 64'(vt[k].r));
            chk($sformatf("v%0d_ovf", k), 64'(overflow), 64'(vt[k].ov));
            chk($sformatf("v%0d_gocnt", k), 64'(go_cnt), 64'd1);
            chk($sformatf("v%0d_gidx", k), 64'(grant_idx), 64'(vt[k].id));
            req = '0;
            step();
            chk($sformatf("v%0d_ackpulse", k), 64'(ack), 64'd0);
            chk($sformatf("v%0d_idle", k), 64'(active), 64'd0);
        end

        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 64'(100 * (i + 1)), 32'(7 + 2 * i));
        req = '1;
        cyc = 0;
        found = 0;
        last = 0;
        while (found < 5 && cyc < 400) begin
            step();
            if (ack != 0) begin
                chk($sformatf("rr%0d_ack", found), 64'(ack), 64'(4'b1 << ord[found]));
                chk($sformatf("rr%0d_quot", found), 64'(quot), 64'(eq[ord[found]]));
                chk($sformatf("rr%0d_rem", found), 64'(rem), 64'(er[ord[found]]));
                chk($sformatf("rr%0d_time", found), 64'(cyc - last), found == 0 ? 64'd35 : 64'd36);
                last = cyc;
                found++;
                if (found == 5) req = '0;
            end
        end
        chk("rr_count", 64'(found), 64'd5);
        step();

        set_op(1, 64'd500, 32'd7);
        set_op(3, 64'd400, 32'd13);
        req = 4'b1010;
        cyc = 0;
        ack1_cnt = 0;
        ack3_at = -1;
        while (cyc < 150 && ack3_at < 0) begin
            step();
            if (cyc == 6) req[1] = 1'b0;
            if (ack[1]) ack1_cnt++;
            if (cyc == 20) begin
                chk("cx_busy", 64'(div_busy), 64'd1);
                chk("cx_active_wait", 64'(active), 64'd1);
            end
            if (cyc == 35) begin
                chk("cx_quot_upd", 64'(quot), 64'd71);
                chk("cx_rem_upd", 64'(rem), 64'd3);
            end
            if (cyc == 36) chk("cx_idle", 64'(active), 64'd0);
            if (ack[3]) ack3_at = cyc;
        end
        chk("cx_no_ack1", 64'(ack1_cnt), 64'd0);
        chk("cx_ack3_time", 64'(ack3_at), 64'd71);
        chk("cx_ack3_quot", 64'(quot), 64'd30);
        chk("cx_ack3_rem", 64'(rem), 64'd10);
        req = '0;
        step();

        set_op(0, 64'd100, 32'd7);
        req = 4'b0001;
        cyc = 0;
        while (cyc < 10) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk_reset("mid");
        chk("mid_div_busy", 64'(div_busy), 64'd1);
        go_cnt = 0;
        go_at = -1;
        while (cyc < 200 && ack == 0) begin
            step();
            if (div_go && go_at < 0) go_at = cyc;
        end
        chk("mid_go_time", 64'(go_at), 64'd35);
        chk("mid_ack_time", 64'(cyc), 64'd69);
        chk("mid_ack", 64'(ack), 64'd1);
        chk("mid_quot", 64'(quot), 64'd14);
        chk("mid_rem", 64'(rem), 64'd2);
        chk("mid_gocnt", 64'(go_cnt), 64'd1);
        req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
